// File: rtl/mcu_spi_port_mux.sv
// Purpose : arbitrates several MCU SPI ports onto one core-side SPI link; a qualified
//           request moves the selection, with a chip-select guard after every switch.
// Latency : data path is combinational; a selection change lands 2 + QUAL_CYCLES + 1 edges
//           after the requesting csn falls. There is no backpressure: a switch is deferred
//           while the selected port holds csn low, so a frame in progress is never cut.
// Ports   : clk32/por_n       clock, asynchronous active-low reset
//           port_sclk/csn/mosi per-port SPI from the MCUs (raw pins feed the data path)
//           port_miso/intn     core data/interrupt broadcast to every port
//           mcu_sclk/csn/mosi  selected SPI toward the core; mcu_miso/intn from the core
//           sel_port/switched  selected index and a one-cycle strobe on every change
module mcu_spi_port_mux #(
  parameter int NPORTS       = 2,
  parameter int DEFAULT_PORT = 0,
  parameter int QUAL_CYCLES  = 4,
  parameter int IDLE_TIMEOUT = 0,
  parameter int GUARD_CYCLES = 2
) (
  input  logic              clk32,
  input  logic              por_n,
  input  logic [NPORTS-1:0] port_sclk,
  input  logic [NPORTS-1:0] port_csn,
  input  logic [NPORTS-1:0] port_mosi,
  output logic [NPORTS-1:0] port_miso,
  output logic [NPORTS-1:0] port_intn,
  output logic              mcu_sclk,
  output logic              mcu_csn,
  output logic              mcu_mosi,
  input  logic              mcu_miso,
  input  logic              mcu_intn,
  output logic [1:0]        sel_port,
  output logic              switched
);

  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  // Idle counter only has to reach IDLE_TIMEOUT-1: the release fires on the idle cycle
  // that would take it to IDLE_TIMEOUT.
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [QW-1:0] QUAL_MAX   = QW'(QUAL_CYCLES);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST  = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [1:0]    DEF_SEL    = 2'(DEFAULT_PORT);

  typedef enum logic [1:0] {S_HOME, S_EXT, S_GUARD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic             r_switched;
  logic             w_switch;
  logic [GW-1:0]    r_guard;
  logic [IW-1:0]    r_idle;
  logic [NPORTS-1:0] r_csn_s1;
  logic [NPORTS-1:0] r_csn_s2;
  logic [QW-1:0]    r_qual [NPORTS];

  // Pins widened to 4 so a 2-bit sel_port can index them for any NPORTS.
  logic [3:0]       w_csn_s2_pad;
  logic [3:0]       w_csn_raw_pad;
  logic [3:0]       w_sclk_pad;
  logic [3:0]       w_mosi_pad;
  logic             w_sel_idle;
  logic             w_req_vld;
  logic [1:0]       w_req_idx;
  logic             w_idle_expire;

  always_comb begin
    w_csn_s2_pad                = 4'hF;
    w_csn_raw_pad               = 4'hF;
    w_sclk_pad                  = 4'h0;
    w_mosi_pad                  = 4'h0;
    w_csn_s2_pad[NPORTS-1:0]  = r_csn_s2;
    w_csn_raw_pad[NPORTS-1:0] = port_csn;
    w_sclk_pad[NPORTS-1:0]    = port_sclk;
    w_mosi_pad[NPORTS-1:0]    = port_mosi;
  end

  assign w_sel_idle = w_csn_s2_pad[r_sel];

  // Descending scan so the lowest qualifying index wins. The selected port's counter is
  // held at 0, so it can never appear as a requester.
  always_comb begin
    w_req_vld = 1'b0;
    w_req_idx = 2'b00;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (r_qual[i] == QUAL_MAX) begin
        w_req_vld = 1'b1;
        w_req_idx = 2'(i);
      end
    end
  end

  assign w_idle_expire = (IDLE_TIMEOUT > 0) && (r_state == S_EXT) && w_sel_idle &&
                         (r_idle == IDLE_LAST);

  // csn synchronisers; reset to idle-high so a frame active at reset release is not
  // seen as a fresh request until it has been observed for the full qualify window.
  always_ff @(posedge clk32 or negedge por_n) begin
    if (!por_n) begin
      r_csn_s1 <= '1;
      r_csn_s2 <= '1;
    end else begin
      r_csn_s1 <= port_csn;
      r_csn_s2 <= r_csn_s1;
    end
  end

  always_ff @(posedge clk32 or negedge por_n) begin
    if (!por_n) begin
      for (int i = 0; i < NPORTS; i++) r_qual[i] <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_switch || (2'(i) == r_sel) || r_csn_s2[i]) r_qual[i] <= '0;
        else if (r_qual[i] != QUAL_MAX)                   r_qual[i] <= r_qual[i] + QW'(1);
      end
    end
  end

  always_ff @(posedge clk32 or negedge por_n) begin
    if (!por_n)                                        r_idle <= '0;
    else if ((r_state != S_EXT) || w_switch || !w_sel_idle) r_idle <= '0;
    else if (r_idle != IDLE_LAST)                      r_idle <= r_idle + IW'(1);
  end

  // State register (with selection, strobe and guard that move with the FSM).
  always_ff @(posedge clk32 or negedge por_n) begin
    if (!por_n) begin
      r_state    <= S_HOME;
      r_sel      <= DEF_SEL;
      r_switched <= 1'b0;
      r_guard    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_switched <= w_switch;
      if (w_switch)             r_guard <= GUARD_LOAD;
      else if (r_guard != '0)   r_guard <= r_guard - GW'(1);
    end
  end

  // Next state: requests beat idle release; GUARD leaves on the edge the guard hits 0.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_switch    = 1'b0;
    case (r_state)
      S_HOME, S_EXT: begin
        if (w_sel_idle && w_req_vld) begin
          w_switch  = 1'b1;
          w_sel_nxt = w_req_idx;
        end else if (w_idle_expire) begin
          w_switch  = 1'b1;
          w_sel_nxt = DEF_SEL;
        end
        if (w_switch) w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (r_guard <= GW'(1)) w_state_nxt = (r_sel == DEF_SEL) ? S_HOME : S_EXT;
      end
      default: w_state_nxt = S_HOME;
    endcase
  end

  // Outputs.
  always_comb begin
    mcu_sclk  = w_sclk_pad[r_sel];
    mcu_mosi  = w_mosi_pad[r_sel];
    mcu_csn   = (r_guard != '0) ? 1'b1 : w_csn_raw_pad[r_sel];
    port_miso = {NPORTS{mcu_miso}};
    port_intn = {NPORTS{mcu_intn}};
    sel_port  = r_sel;
    switched  = r_switched;
  end

endmodule

// File: tb/tb_mcu_spi_port_mux.sv
// Purpose : directed checks of mcu_spi_port_mux in two configurations (defaults, and
//           NPORTS=3 with IDLE_TIMEOUT=100).
// Latency : expected switch times are hand-derived: 2 sync + QUAL_CYCLES + 1 edges.
// Ports   : none; drives both instances and reports a single summary line.
module tb_mcu_spi_port_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: defaults.
  logic       a_por_n;
  logic [1:0] a_sclk, a_csn, a_mosi, a_miso_p, a_intn_p;
  logic       a_mcu_sclk, a_mcu_csn, a_mcu_mosi, a_mcu_miso, a_mcu_intn;
  logic [1:0] a_sel;
  logic       a_sw;

  mcu_spi_port_mux u_dut_a (
    .clk32(clk), .por_n(a_por_n),
    .port_sclk(a_sclk), .port_csn(a_csn), .port_mosi(a_mosi),
    .port_miso(a_miso_p), .port_intn(a_intn_p),
    .mcu_sclk(a_mcu_sclk), .mcu_csn(a_mcu_csn), .mcu_mosi(a_mcu_mosi),
    .mcu_miso(a_mcu_miso), .mcu_intn(a_mcu_intn),
    .sel_port(a_sel), .switched(a_sw)
  );

  // Instance B: three ports, idle release after 100 cycles.
  logic       b_por_n;
  logic [2:0] b_sclk, b_csn, b_mosi, b_miso_p, b_intn_p;
  logic       b_mcu_sclk, b_mcu_csn, b_mcu_mosi, b_mcu_miso, b_mcu_intn;
  logic [1:0] b_sel;
  logic       b_sw;

  mcu_spi_port_mux #(.NPORTS(3), .IDLE_TIMEOUT(100)) u_dut_b (
    .clk32(clk), .por_n(b_por_n),
    .port_sclk(b_sclk), .port_csn(b_csn), .port_mosi(b_mosi),
    .port_miso(b_miso_p), .port_intn(b_intn_p),
    .mcu_sclk(b_mcu_sclk), .mcu_csn(b_mcu_csn), .mcu_mosi(b_mcu_mosi),
    .mcu_miso(b_mcu_miso), .mcu_intn(b_mcu_intn),
    .sel_port(b_sel), .switched(b_sw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sw_cnt;

    a_por_n = 1'b0; a_sclk = 2'b00; a_csn = 2'b11; a_mosi = 2'b00;
    a_mcu_miso = 1'b0; a_mcu_intn = 1'b1;
    b_por_n = 1'b0; b_sclk = 3'b000; b_csn = 3'b111; b_mosi = 3'b000;
    b_mcu_miso = 1'b0; b_mcu_intn = 1'b1;
    #12;

    // ---------------- instance A ----------------
    check("a_rst_sel", a_sel, 0);
    check("a_rst_sw", a_sw, 0);
    check("a_rst_csn_hi", a_mcu_csn, 1);
    a_csn[0] = 1'b0; #1;
    check("a_rst_csn_follow", a_mcu_csn, 0);
    a_csn[0] = 1'b1;
    check("b_rst_sel", b_sel, 0);
    check("b_rst_sw", b_sw, 0);

    tick(); a_por_n = 1'b1;

    // Data path at port 0 and broadcast back to all ports.
    a_sclk = 2'b10; a_mosi = 2'b01; #1;
    check("a_sclk_p0_lo", a_mcu_sclk, 0);
    check("a_mosi_p0_hi", a_mcu_mosi, 1);
    a_sclk = 2'b01; a_mosi = 2'b10; #1;
    check("a_sclk_p0_hi", a_mcu_sclk, 1);
    check("a_mosi_p0_lo", a_mcu_mosi, 0);
    a_mcu_miso = 1'b1; a_mcu_intn = 1'b0; #1;
    check("a_miso_bcast1", a_miso_p, 2'b11);
    check("a_intn_bcast0", a_intn_p, 2'b00);
    a_mcu_miso = 1'b0; a_mcu_intn = 1'b1; #1;
    check("a_miso_bcast0", a_miso_p, 2'b00);
    check("a_intn_bcast1", a_intn_p, 2'b11);

    // Port 1 low for only 3 cycles: one short of qualifying.
    a_csn[1] = 1'b0;
    tick(); tick(); tick();
    a_csn[1] = 1'b1;
    sw_cnt = 0;
    for (int n = 0; n < 10; n++) begin tick(); sw_cnt += int'(a_sw); end
    check("a_short_req_nosw", sw_cnt, 0);
    check("a_short_req_sel", a_sel, 0);

    // Port 0 mid-frame while port 1 qualifies: switch waits for port 0 csn high.
    a_csn = 2'b00;
    sw_cnt = 0;
    for (int n = 0; n < 20; n++) begin tick(); sw_cnt += int'(a_sw); end
    check("a_midframe_nosw", sw_cnt, 0);
    check("a_midframe_sel", a_sel, 0);
    check("a_midframe_csn", a_mcu_csn, 0);
    a_csn[0] = 1'b1;
    tick();
    check("a_defer_e1_sel", a_sel, 0);
    tick();
    check("a_defer_e2_sel", a_sel, 0);
    check("a_defer_e2_sw", a_sw, 0);
    tick();
    check("a_defer_e3_sel", a_sel, 1);
    check("a_defer_e3_sw", a_sw, 1);
    check("a_defer_e3_guard", a_mcu_csn, 1);
    tick();
    check("a_defer_e4_sw", a_sw, 0);
    check("a_defer_e4_guard", a_mcu_csn, 1);
    tick();
    check("a_defer_e5_csn", a_mcu_csn, 0);

    // Asynchronous reset while port 1 selected, port 1 still held low.
    a_por_n = 1'b0; #1;
    check("a_arst_sel", a_sel, 0);
    check("a_arst_sw", a_sw, 0);
    check("a_arst_csn", a_mcu_csn, 1);
    tick(); a_por_n = 1'b1;

    // Qualification restarts from 0: switch on the 7th edge after release.
    for (int n = 1; n <= 12; n++) begin
      tick();
      check($sformatf("a_lat_sw_%0d", n), a_sw, (n == 7) ? 1 : 0);
      check($sformatf("a_lat_sel_%0d", n), a_sel, (n >= 7) ? 1 : 0);
      check($sformatf("a_lat_csn_%0d", n), a_mcu_csn, (n >= 9) ? 0 : 1);
    end
    a_sclk = 2'b10; a_mosi = 2'b01; #1;
    check("a_sclk_p1", a_mcu_sclk, 1);
    check("a_mosi_p1", a_mcu_mosi, 0);
    a_csn[1] = 1'b1; #1;
    check("a_csn_p1_hi", a_mcu_csn, 1);

    // Sticky selection with IDLE_TIMEOUT=0.
    sw_cnt = 0;
    for (int n = 0; n < 150; n++) begin tick(); sw_cnt += int'(a_sw); end
    check("a_sticky_nosw", sw_cnt, 0);
    check("a_sticky_sel", a_sel, 1);

    // ---------------- instance B ----------------
    tick(); b_por_n = 1'b1;
    b_csn = 3'b001;  // ports 1 and 2 request on the same cycle
    for (int n = 0; n < 6; n++) tick();
    check("b_tie_e6_sel", b_sel, 0);
    check("b_tie_e6_sw", b_sw, 0);
    tick();
    check("b_tie_e7_sel", b_sel, 1);
    check("b_tie_e7_sw", b_sw, 1);
    b_csn[2] = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    check("b_ext_sel", b_sel, 1);

    // Idle for 99 cycles: no release.
    b_csn[1] = 1'b1;
    sw_cnt = 0;
    for (int n = 0; n < 99; n++) begin tick(); sw_cnt += int'(b_sw); end
    b_csn[1] = 1'b0;
    for (int n = 0; n < 10; n++) begin tick(); sw_cnt += int'(b_sw); end
    check("b_idle99_nosw", sw_cnt, 0);
    check("b_idle99_sel", b_sel, 1);

    // Idle for 100 cycles: release to port 0 with a strobe.
    b_csn[1] = 1'b1;
    sw_cnt = 0;
    for (int n = 0; n < 100; n++) begin tick(); sw_cnt += int'(b_sw); end
    check("b_idle100_pre_nosw", sw_cnt, 0);
    b_csn[1] = 1'b0;
    tick();
    check("b_idle100_e101_sel", b_sel, 1);
    check("b_idle100_e101_sw", b_sw, 0);
    tick();
    check("b_idle100_e102_sel", b_sel, 0);
    check("b_idle100_e102_sw", b_sw, 1);

    // Port 2 takes the link.
    b_csn[1] = 1'b1; b_csn[2] = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    check("b_p2_e6_sel", b_sel, 0);
    tick();
    check("b_p2_e7_sel", b_sel, 2);
    check("b_p2_e7_sw", b_sw, 1);
    b_sclk = 3'b100; b_mosi = 3'b011; #1;
    check("b_sclk_p2", b_mcu_sclk, 1);
    check("b_mosi_p2", b_mcu_mosi, 0);

    // Asynchronous reset while port 2 selected; miso broadcast unaffected.
    b_mcu_miso = 1'b1; #1;
    check("b_miso_pre", b_miso_p, 3'b111);
    #2; b_por_n = 1'b0; #1;
    check("b_arst_sel", b_sel, 0);
    check("b_arst_sw", b_sw, 0);
    check("b_arst_miso", b_miso_p, 3'b111);
    b_mcu_miso = 1'b0; b_mcu_intn = 1'b0; #1;
    check("b_arst_miso0", b_miso_p, 3'b000);
    check("b_arst_intn0", b_intn_p, 3'b000);

    // Release mid-frame on port 0: no spurious switch.
    b_csn = 3'b110;
    tick(); b_por_n = 1'b1;
    sw_cnt = 0;
    for (int n = 0; n < 12; n++) begin tick(); sw_cnt += int'(b_sw); end
    check("b_rel_nosw", sw_cnt, 0);
    check("b_rel_sel", b_sel, 0);
    check("b_rel_csn", b_mcu_csn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
